chaos_chip_serializer: RTL and testbench
========================================

// Module: chaos_chip_serializer
// PURPOSE
// - Downstream of the wire-shuffler stage. Takes 256-bit shuffled chaos words and emits them as a serial chip stream for the DCSK modulator.
// - Double-buffered (active shift register + one pending word), so back-to-back words stream with no gap.
// - Programmable chip rate.
// PARAMETERS
// WORD_W     256  bits per shuffled chaos word (chips per word)
// DIV_W      8    width of chip-rate divider setting
// LSB_FIRST  1    1: chip order bit 0..WORD_W-1; 0: WORD_W-1..0
// PORTS
// clk           in   1       single clock, rising edge
// rst_n         in   1       asynchronous, active-low reset
// en_i          in   1       run enable; low = pause (freeze counters, hold outputs)
// chip_div_i    in   DIV_W   clocks per chip minus 1; sampled at each word load
// s_word_i      in   WORD_W  shuffled chaos word
// s_valid_i     in   1       word valid
// s_ready_o     out  1       word accepted when s_valid_i & s_ready_o
// chip_o        out  1       current chip value (registered)
// chip_valid_o  out  1       one-cycle strobe per emitted chip
// word_start_o  out  1       strobe coincident with first chip of each word
// underrun_o    out  1       one-cycle pulse: word finished, no pending word, en_i=1
// busy_o        out  1       state==RUN
// BEHAVIOUR
// - Reset (async assert, sync deassert internally):
//   - all outputs 0, except s_ready_o=1
//   - state IDLE; pend_valid=0; counters 0; div_q=0.
// - States:
//   - IDLE: pend_valid & en_i -> RUN. Load shift<=pend, div_q<=chip_div_i, div_cnt=0, bit_cnt=0, pend_valid<=0.
//   - RUN: div_cnt counts 0..div_q. At div_cnt==div_q & en_i ("tick"): next cycle chip_o=shift[cur], chip_valid_o=1; bit_cnt++, div_cnt<=0.
//   - RUN, last tick (bit_cnt==WORD_W-1):
//     - pend_valid -> reload shift from pend, stay RUN, bit_cnt=0, div_q re-sampled.
//     - else -> IDLE, and pulse underrun_o the same cycle as the last chip_valid_o.
// - s_ready_o = ~pend_valid | last_tick.
//   - Accept on last_tick: pending is refilled on the same edge it is drained. No loss, no double-load.
// - Latency:
//   - Accept at cycle T from IDLE -> pend at T+1, RUN load at T+2, first chip_valid_o at T+3+div_q.
//   - Chip spacing exactly div_q+1 clocks.
//   - One word = WORD_W*(div_q+1) clocks.
//   - Back-to-back words: no gap between last chip and next word's first chip spacing.
// - word_start_o is high with chip_valid_o for bit_cnt==0 only.
// - en_i low:
//   - no ticks, counters and state hold, chip_valid_o=0, chip_o holds.
//   - s_ready_o still follows pend_valid, so a word may be accepted while paused.
// - chip_div_i changes mid-word have no effect until the next word load.
// - chip_div_i=0: a chip every clock (full rate).
// - div_cnt and bit_cnt never wrap past limits: bit_cnt width $clog2(WORD_W), resets to 0 after WORD_W-1.
// - rst_n asserted mid-word: current and pending words are discarded; no further strobes.
// STRUCTURE
// - Package chaos_ser_pkg:
//   - typedef enum logic {SER_IDLE, SER_RUN} ser_state_t
//   - localparam CHIP_WORD_W=256
//   - typedef logic [CHIP_WORD_W-1:0] chip_word_t
// - Sub-module chip_rate_divider:
//   - ports clk, rst_n, en_i, load_i, div_i, tick_o
//   - owns div_cnt/div_q
//   - tick_o when cnt==div_q & en_i
// - Top holds FSM, pend register, shift/bit select, output registers.
// TESTING
// 1. Reset: rst_n=0 -> all outputs 0, s_ready_o=1. Release, no s_valid -> no chip_valid_o for 1000 clocks.
// 2. Single word 256'h1 (LSB_FIRST=1), chip_div_i=3, en=1 at T:
//    - first chip_valid_o at T+6 with chip_o=1, word_start_o=1
//    - remaining 255 strobes every 4 clocks, chip_o=0
//    - underrun_o with the 256th.
// 3. Back-to-back: three words A5A5.., FFFF.., 0000.., div=0:
//    - 768 consecutive chip_valid_o cycles, no bubble
//    - word_start_o at chips 0/256/512
//    - one underrun_o at chip 767
//    - s_valid held high: accepts only on last_tick.
// 4. Pause: en_i low for 10 clocks at chip 100, div=1:
//    - no strobes during the pause
//    - chip 101 arrives 2 clocks after en_i rises
//    - total strobe count still 256.
// 5. Rate change: chip_div_i 1->5 mid-word:
//    - word 1 spacing stays 2
//    - word 2 spacing is 6.
// 6. Async reset mid-word at chip 50, pending word loaded:
//    - outputs 0 immediately
//    - after release, no strobes and s_ready_o=1.

Source files
------------

// File: rtl/chaos_ser_pkg.sv
// Shared types and constants for the chaos chip serializer.
package chaos_ser_pkg;

  localparam int unsigned CHIP_WORD_W = 256;

  typedef logic [CHIP_WORD_W-1:0] chip_word_t;

  typedef enum logic {SER_IDLE, SER_RUN} ser_state_t;

endpackage

// File: rtl/chip_rate_divider.sv
// Chip-rate divider: one tick every div_q+1 enabled clocks; div_q latched on load.
module chip_rate_divider #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;

  assign tick_o = en_i & (div_cnt == div_q);

  // Load restarts the chip period with the freshly sampled rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      div_cnt <= '0;
    end else if (load_i) begin
      div_q   <= div_i;
      div_cnt <= '0;
    end else if (tick_o) begin
      div_cnt <= '0;
    end else if (en_i) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/chaos_chip_serializer.sv
// Double-buffered serializer turning shuffled chaos words into a paced chip stream.
module chaos_chip_serializer
  import chaos_ser_pkg::*;
#(
  parameter int unsigned WORD_W    = CHIP_WORD_W,
  parameter int unsigned DIV_W     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  chip_div_i,
  input  logic [WORD_W-1:0] s_word_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              chip_o,
  output logic              chip_valid_o,
  output logic              word_start_o,
  output logic              underrun_o,
  output logic              busy_o
);

  localparam int unsigned      BIT_W    = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  logic [1:0]        rst_sync;
  logic              rst_int_n;
  ser_state_t        state;
  ser_state_t        state_nxt;
  logic [WORD_W-1:0] pend_q;
  logic              pend_valid;
  logic [WORD_W-1:0] shift_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_sel;
  logic              run;
  logic              tick;
  logic              last_tick;
  logic              load;
  logic              accept;

  // Asynchronous assert, synchronous release of the internal reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign run       = (state == SER_RUN);
  assign last_tick = tick & (bit_cnt == LAST_BIT);
  assign s_ready_o = ~pend_valid | last_tick;
  assign accept    = s_valid_i & s_ready_o;
  assign busy_o    = run;
  assign bit_sel   = LSB_FIRST ? bit_cnt : (LAST_BIT - bit_cnt);

  chip_rate_divider #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .en_i   (en_i & run),
    .load_i (load),
    .div_i  (chip_div_i),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= SER_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      SER_IDLE: begin
        if (pend_valid & en_i) begin
          state_nxt = SER_RUN;
          load      = 1'b1;
        end
      end
      SER_RUN: begin
        if (last_tick) begin
          if (pend_valid) load = 1'b1;
          else            state_nxt = SER_IDLE;
        end
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

  // Pending slot: a refill on the draining edge keeps it full.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      pend_q     <= '0;
      pend_valid <= 1'b0;
    end else if (accept) begin
      pend_q     <= s_word_i;
      pend_valid <= 1'b1;
    end else if (load) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shift_q <= pend_q;
      bit_cnt <= '0;
    end else if (tick) begin
      bit_cnt <= last_tick ? '0 : bit_cnt + BIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      chip_o       <= 1'b0;
      chip_valid_o <= 1'b0;
      word_start_o <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      chip_valid_o <= tick;
      word_start_o <= tick & (bit_cnt == '0);
      underrun_o   <= last_tick & ~pend_valid;
      if (tick) chip_o <= shift_q[bit_sel];
    end
  end

endmodule

// File: tb/tb_chaos_chip_serializer.sv
// Randomized self-checking bench for chaos_chip_serializer against a chip-schedule model.
module tb_chaos_chip_serializer;
  import chaos_ser_pkg::*;

  localparam int unsigned W  = CHIP_WORD_W;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_i = 1'b0;
  logic [DW-1:0] chip_div_i = '0;
  chip_word_t    s_word_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o, chip_o, chip_valid_o, word_start_o, underrun_o, busy_o;

  chaos_chip_serializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .chip_div_i   (chip_div_i),
    .s_word_i     (s_word_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .chip_o       (chip_o),
    .chip_valid_o (chip_valid_o),
    .word_start_o (word_start_o),
    .underrun_o   (underrun_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: a word's chip k is due after (k+1)*(div+1) enabled clocks of that word.
  chip_word_t pend_q[$];
  chip_word_t m_word;
  int         m_div, m_e, m_k;
  bit         m_busy, m_chip, m_ready, m_fire, m_last, m_acc;
  int         n_cv, n_ws, n_ur, cyc, t_first, t_last;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    m_word = '0;
    m_div  = 0;
    m_e    = 0;
    m_busy = 1'b0;
    m_chip = 1'b0;
    m_acc  = 1'b0;
  endtask

  task automatic clear_stats();
    n_cv = 0; n_ws = 0; n_ur = 0; t_first = -1; t_last = -1;
  endtask

  // One clock: predict, check s_ready, advance model across the edge, check outputs.
  task automatic run_cycle();
    bit         exp_cv, exp_ws, exp_ur;
    chip_word_t w;
    #2;
    m_fire  = m_busy && en_i && (((m_e + 1) % (m_div + 1)) == 0);
    m_k     = (m_e + 1) / (m_div + 1) - 1;
    m_last  = m_fire && (m_k == W - 1);
    m_ready = (pend_q.size() == 0) || m_last;
    check_eq("s_ready", s_ready_o, m_ready);
    m_acc  = s_valid_i && m_ready;
    w      = s_word_i;
    exp_cv = m_fire;
    exp_ws = m_fire && (m_k == 0);
    exp_ur = m_last && (pend_q.size() == 0);
    if (m_fire) m_chip = m_word[m_k];
    if (m_busy) begin
      if (en_i) m_e++;
      if (m_last) begin
        if (pend_q.size() > 0) begin
          m_word = pend_q.pop_front();
          m_div  = int'(chip_div_i);
          m_e    = 0;
        end else begin
          m_busy = 1'b0;
        end
      end
    end else if (pend_q.size() > 0 && en_i) begin
      m_word = pend_q.pop_front();
      m_div  = int'(chip_div_i);
      m_e    = 0;
      m_busy = 1'b1;
    end
    if (m_acc) pend_q.push_back(w);
    @(posedge clk);
    #1;
    cyc++;
    check_eq("chip_valid", chip_valid_o, exp_cv);
    check_eq("word_start", word_start_o, exp_ws);
    check_eq("underrun", underrun_o, exp_ur);
    check_eq("chip", chip_o, m_chip);
    check_eq("busy", busy_o, m_busy);
    if (chip_valid_o) begin
      n_cv++;
      if (t_first < 0) t_first = cyc;
      t_last = cyc;
    end
    if (word_start_o) n_ws++;
    if (underrun_o)   n_ur++;
  endtask

  task automatic send_word(input chip_word_t w, input string tag);
    bit done = 1'b0;
    s_word_i  = w;
    s_valid_i = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      run_cycle();
      done = m_acc;
    end
    s_valid_i = 1'b0;
    if (!done) check_eq({tag, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      run_cycle();
      done = !m_busy && (pend_q.size() == 0);
    end
    if (!done) check_eq({tag, "_idle_timeout"}, 0, 1);
    run_cycle();
  endtask

  function automatic chip_word_t rand_word();
    chip_word_t w;
    for (int j = 0; j < W / 32; j++) w[j*32 +: 32] = $urandom();
    return w;
  endfunction

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    chip_word_t wa, wf, wz;
    cyc = 0;
    model_reset();
    clear_stats();

    // Reset values
    #1;
    check_eq("rst_s_ready", s_ready_o, 1);
    check_eq("rst_chip", chip_o, 0);
    check_eq("rst_chip_valid", chip_valid_o, 0);
    check_eq("rst_word_start", word_start_o, 0);
    check_eq("rst_underrun", underrun_o, 0);
    check_eq("rst_busy", busy_o, 0);
    @(posedge clk); #1;
    run_cycle(); run_cycle();
    rst_n = 1'b1;
    en_i  = 1'b1;
    repeat (1000) run_cycle();
    check_eq("idle_no_strobes", n_cv, 0);

    // Single word 1, div 3
    clear_stats();
    chip_div_i = 8'd3;
    send_word(chip_word_t'(1), "single");
    n = 1;
    while (!chip_valid_o && n < 50) begin run_cycle(); n++; end
    check_eq("single_latency", n, 6);
    check_eq("single_first_chip", chip_o, 1);
    check_eq("single_first_ws", word_start_o, 1);
    wait_idle("single");
    check_eq("single_count", n_cv, 256);
    check_eq("single_span", t_last - t_first, 255 * 4);
    check_eq("single_ws", n_ws, 1);
    check_eq("single_ur", n_ur, 1);

    // Back-to-back at full rate
    clear_stats();
    chip_div_i = 8'd0;
    wa = '0; wf = '0; wz = '0;
    for (int j = 0; j < W / 16; j++) begin
      wa[j*16 +: 16] = 16'hA5A5;
      wf[j*16 +: 16] = 16'hFFFF;
    end
    send_word(wa, "b2b_a");
    send_word(wf, "b2b_f");
    send_word(wz, "b2b_0");
    wait_idle("b2b");
    check_eq("b2b_count", n_cv, 768);
    check_eq("b2b_span", t_last - t_first, 767);
    check_eq("b2b_ws", n_ws, 3);
    check_eq("b2b_ur", n_ur, 1);

    // Pause after 100 chips, div 1
    clear_stats();
    chip_div_i = 8'd1;
    send_word(rand_word(), "pause");
    for (int i = 0; i < 2000 && n_cv < 100; i++) run_cycle();
    en_i = 1'b0;
    repeat (10) run_cycle();
    check_eq("pause_hold", n_cv, 100);
    en_i = 1'b1;
    n = 1;
    run_cycle();
    while (!chip_valid_o && n < 20) begin run_cycle(); n++; end
    check_eq("pause_resume_lat", n, 2);
    wait_idle("pause");
    check_eq("pause_count", n_cv, 256);

    // Rate change mid-word 1 -> 5
    clear_stats();
    chip_div_i = 8'd1;
    send_word(rand_word(), "rate_w1");
    send_word(rand_word(), "rate_w2");
    repeat (50) run_cycle();
    chip_div_i = 8'd5;
    wait_idle("rate");
    check_eq("rate_count", n_cv, 512);
    check_eq("rate_span", t_last - t_first, 255 * 2 + 256 * 6);

    // Async reset mid-word with a pending word
    clear_stats();
    chip_div_i = 8'd2;
    send_word(rand_word(), "arst_w1");
    send_word(rand_word(), "arst_w2");
    for (int i = 0; i < 2000 && n_cv < 50; i++) run_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_chip_valid", chip_valid_o, 0);
    check_eq("arst_chip", chip_o, 0);
    check_eq("arst_busy", busy_o, 0);
    check_eq("arst_s_ready", s_ready_o, 1);
    model_reset();
    run_cycle(); run_cycle();
    rst_n = 1'b1;
    clear_stats();
    repeat (60) run_cycle();
    check_eq("arst_no_strobes", n_cv, 0);
    check_eq("arst_ready_after", s_ready_o, 1);

    // Randomized traffic, pauses and rate changes
    clear_stats();
    for (int i = 0; i < 8000; i++) begin
      en_i = ($urandom_range(7) != 0);
      if ($urandom_range(63) == 0) chip_div_i = DW'($urandom_range(2));
      if (!s_valid_i && $urandom_range(3) == 0) begin
        s_word_i  = rand_word();
        s_valid_i = 1'b1;
      end
      run_cycle();
      if (m_acc) s_valid_i = 1'b0;
    end
    s_valid_i = 1'b0;
    en_i = 1'b1;
    wait_idle("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
